// File: rtl/mc_control_fsm_pkg.sv
// Shared opcodes, state encoding and datapath select codes for the multicycle control FSM.
package mc_control_fsm_pkg;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_EX    = 4'd2,
    S_MEM   = 4'd3,
    S_WB    = 4'd4,
    S_JALR2 = 4'd5,
    S_PCINC = 4'd6,
    S_HALT  = 4'd7
  } state_t;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_ALU    = 2'b10;

  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_RS1 = 1'b1;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b01;
  localparam logic [1:0] ALUOP_BRANCH = 2'b10;

  localparam logic ADDR_PC     = 1'b0;
  localparam logic ADDR_ALUOUT = 1'b1;

  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

  typedef struct packed {
    logic arith;
    logic arith_imm;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic ecall;
    logic illegal;
  } inst_class_t;

endpackage

// File: rtl/mc_opcode_class.sv
// Maps a 7-bit opcode onto a one-hot instruction class.
module mc_opcode_class
  import mc_control_fsm_pkg::*;
(
  input  logic [6:0]  opcode,
  output inst_class_t cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_ARITH:     cls.arith     = 1'b1;
      OP_ARITH_IMM: cls.arith_imm = 1'b1;
      OP_LOAD:      cls.load      = 1'b1;
      OP_STORE:     cls.store     = 1'b1;
      OP_BRANCH:    cls.branch    = 1'b1;
      OP_JAL:       cls.jal       = 1'b1;
      OP_JALR:      cls.jalr      = 1'b1;
      OP_ECALL:     cls.ecall     = 1'b1;
      default:      cls.illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle processor control FSM: sequences fetch, decode, execute, memory and write-back.
//
// state | meaning
// IF    | fetch instruction from PC, wait for mem_ready
// ID    | decode, ALUOut = PC + imm
// EX    | execute / address calc / branch resolve / JAL
// MEM   | data access at ALUOut, hold until mem_ready
// WB    | register-file write-back
// JALR2 | JALR link write and jump to ALUOut
// PCINC | PC = PC + 4
// HALT  | stopped after ECALL until reset
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter bit HALT_ON_ECALL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        bcond,
  output logic        pc_write,
  output logic        ir_write,
  output logic        aluout_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op_sel,
  output logic        pc_source,
  output logic        halted,
  output logic [3:0]  state_o
);

  state_t      r_state;
  state_t      w_next_state;
  inst_class_t w_cls;
  logic        w_unused_inst;

  assign w_unused_inst = ^inst[31:7];

  mc_opcode_class u_opcode_class (
    .opcode (inst[6:0]),
    .cls    (w_cls)
  );

  // Async reset drops straight to IF so MEM/HALT requests vanish without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IF;
    else       r_state <= w_next_state;
  end

  assign state_o = r_state;

  always_comb begin
    w_next_state = r_state;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    aluout_write = 1'b0;
    i_or_d       = ADDR_PC;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    alu_op_sel   = ALUOP_ADD;
    pc_source    = PCSRC_ALU;
    halted       = 1'b0;

    case (r_state)
      S_IF: begin
        mem_read = 1'b1;
        i_or_d   = ADDR_PC;
        if (mem_ready) begin
          ir_write     = 1'b1;
          w_next_state = S_ID;
        end
      end

      S_ID: begin
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_IMM;
        alu_op_sel   = ALUOP_ADD;
        aluout_write = 1'b1;
        if (w_cls.ecall)        w_next_state = HALT_ON_ECALL ? S_HALT : S_PCINC;
        else if (w_cls.illegal) w_next_state = S_PCINC;
        else                    w_next_state = S_EX;
      end

      S_EX: begin
        if (w_cls.arith || w_cls.arith_imm) begin
          alu_src_a    = SRCA_RS1;
          alu_src_b    = w_cls.arith_imm ? SRCB_IMM : SRCB_RS2;
          alu_op_sel   = ALUOP_FUNCT;
          aluout_write = 1'b1;
          w_next_state = S_WB;
        end else if (w_cls.load || w_cls.store) begin
          alu_src_a    = SRCA_RS1;
          alu_src_b    = SRCB_IMM;
          alu_op_sel   = ALUOP_ADD;
          aluout_write = 1'b1;
          w_next_state = S_MEM;
        end else if (w_cls.branch) begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          alu_op_sel = ALUOP_BRANCH;
          if (bcond) begin
            pc_write     = 1'b1;
            pc_source    = PCSRC_ALUOUT;
            w_next_state = S_IF;
          end else begin
            w_next_state = S_PCINC;
          end
        end else if (w_cls.jal) begin
          alu_src_a    = SRCA_PC;
          alu_src_b    = SRCB_FOUR;
          alu_op_sel   = ALUOP_ADD;
          reg_write    = 1'b1;
          wb_sel       = WB_ALU;
          pc_write     = 1'b1;
          pc_source    = PCSRC_ALUOUT;
          w_next_state = S_IF;
        end else if (w_cls.jalr) begin
          alu_src_a    = SRCA_RS1;
          alu_src_b    = SRCB_IMM;
          alu_op_sel   = ALUOP_ADD;
          aluout_write = 1'b1;
          w_next_state = S_JALR2;
        end else begin
          w_next_state = S_PCINC;
        end
      end

      S_MEM: begin
        i_or_d    = ADDR_ALUOUT;
        mem_read  = w_cls.load;
        mem_write = w_cls.store;
        if (mem_ready) w_next_state = w_cls.load ? S_WB : S_PCINC;
      end

      S_WB: begin
        reg_write    = 1'b1;
        wb_sel       = w_cls.load ? WB_MEM : WB_ALUOUT;
        w_next_state = S_PCINC;
      end

      S_JALR2: begin
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_FOUR;
        alu_op_sel   = ALUOP_ADD;
        reg_write    = 1'b1;
        wb_sel       = WB_ALU;
        pc_write     = 1'b1;
        pc_source    = PCSRC_ALUOUT;
        w_next_state = S_IF;
      end

      S_PCINC: begin
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_FOUR;
        alu_op_sel   = ALUOP_ADD;
        pc_write     = 1'b1;
        pc_source    = PCSRC_ALU;
        w_next_state = S_IF;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: w_next_state = S_IF;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle state/output vectors for each instruction class.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        mem_ready = 1'b0;
  logic        bcond = 1'b0;

  logic       pc_write, ir_write, aluout_write, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0] wb_sel, alu_src_b, alu_op_sel;
  logic       alu_src_a, pc_source, halted;
  logic [3:0] state_o;

  logic       pc_write_0, ir_write_0, aluout_write_0, i_or_d_0, mem_read_0, mem_write_0, reg_write_0;
  logic [1:0] wb_sel_0, alu_src_b_0, alu_op_sel_0;
  logic       alu_src_a_0, pc_source_0, halted_0;
  logic [3:0] state_o_0;

  logic [15:0] outs, outs_0;

  int n_checks = 0;
  int n_errors = 0;

  // {pc_write, ir_write, aluout_write, i_or_d, mem_read, mem_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op_sel, pc_source, halted}
  localparam logic [15:0] V_IFN  = {7'b0000100, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] V_IFR  = {7'b0100100, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] V_ID   = {7'b0010000, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] V_EXA  = {7'b0010000, 2'b00, 1'b1, 2'b00, 2'b01, 2'b00};
  localparam logic [15:0] V_EXI  = {7'b0010000, 2'b00, 1'b1, 2'b01, 2'b01, 2'b00};
  localparam logic [15:0] V_EXM  = {7'b0010000, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] V_MEML = {7'b0001100, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] V_MEMS = {7'b0001010, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] V_WBA  = {7'b0000001, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] V_WBL  = {7'b0000001, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] V_PCI  = {7'b1000000, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] V_BRT  = {7'b1000000, 2'b00, 1'b1, 2'b00, 2'b10, 2'b10};
  localparam logic [15:0] V_BRN  = {7'b0000000, 2'b00, 1'b1, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] V_JAL  = {7'b1000001, 2'b10, 1'b0, 2'b10, 2'b00, 2'b10};
  localparam logic [15:0] V_HALT = {7'b0000000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01};

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ADDI  = 32'h00508093;
  localparam logic [31:0] I_LW    = 32'h0000A183;
  localparam logic [31:0] I_SW    = 32'h0030A023;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_ECALL = 32'h00000073;
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  assign outs   = {pc_write, ir_write, aluout_write, i_or_d, mem_read, mem_write, reg_write,
                   wb_sel, alu_src_a, alu_src_b, alu_op_sel, pc_source, halted};
  assign outs_0 = {pc_write_0, ir_write_0, aluout_write_0, i_or_d_0, mem_read_0, mem_write_0, reg_write_0,
                   wb_sel_0, alu_src_a_0, alu_src_b_0, alu_op_sel_0, pc_source_0, halted_0};

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .inst(inst), .mem_ready(mem_ready), .bcond(bcond),
    .pc_write(pc_write), .ir_write(ir_write), .aluout_write(aluout_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
    .pc_source(pc_source), .halted(halted), .state_o(state_o)
  );

  mc_control_fsm #(.HALT_ON_ECALL(1'b0)) dut_noh (
    .clk(clk), .reset(reset), .inst(inst), .mem_ready(mem_ready), .bcond(bcond),
    .pc_write(pc_write_0), .ir_write(ir_write_0), .aluout_write(aluout_write_0), .i_or_d(i_or_d_0),
    .mem_read(mem_read_0), .mem_write(mem_write_0), .reg_write(reg_write_0), .wb_sel(wb_sel_0),
    .alu_src_a(alu_src_a_0), .alu_src_b(alu_src_b_0), .alu_op_sel(alu_op_sel_0),
    .pc_source(pc_source_0), .halted(halted_0), .state_o(state_o_0)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at posedge+1: let inputs settle, check, then advance one clock.
  task automatic step(input string tag, input logic [3:0] est, input logic [15:0] eo);
    #1;
    chk({tag, ".state"}, {28'h0, state_o}, {28'h0, est});
    chk({tag, ".outs"}, {16'h0, outs}, {16'h0, eo});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst.state", {28'h0, state_o}, 32'd0);
    chk("rst.halted", {31'h0, halted}, 32'd0);
    chk("rst.state_noh", {28'h0, state_o_0}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.idle_state", {28'h0, state_o}, 32'd0);
    chk("rst.idle_outs", {16'h0, outs}, {16'h0, V_IFN});

    inst = I_ADD; mem_ready = 1'b1;
    step("add.if", 4'd0, V_IFR);
    step("add.id", 4'd1, V_ID);
    step("add.ex", 4'd2, V_EXA);
    step("add.wb", 4'd4, V_WBA);
    step("add.pcinc", 4'd6, V_PCI);

    inst = I_ADDI;
    step("addi.if", 4'd0, V_IFR);
    step("addi.id", 4'd1, V_ID);
    step("addi.ex", 4'd2, V_EXI);
    step("addi.wb", 4'd4, V_WBA);
    step("addi.pcinc", 4'd6, V_PCI);

    inst = I_LW;
    step("lw.if", 4'd0, V_IFR);
    step("lw.id", 4'd1, V_ID);
    step("lw.ex", 4'd2, V_EXM);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw.memwait", 4'd3, V_MEML);
    mem_ready = 1'b1;
    step("lw.mem", 4'd3, V_MEML);
    step("lw.wb", 4'd4, V_WBL);
    step("lw.pcinc", 4'd6, V_PCI);

    inst = I_SW;
    step("sw.if", 4'd0, V_IFR);
    step("sw.id", 4'd1, V_ID);
    step("sw.ex", 4'd2, V_EXM);
    step("sw.mem", 4'd3, V_MEMS);
    step("sw.pcinc", 4'd6, V_PCI);

    inst = I_BEQ; bcond = 1'b1;
    step("beqt.if", 4'd0, V_IFR);
    step("beqt.id", 4'd1, V_ID);
    step("beqt.ex", 4'd2, V_BRT);

    bcond = 1'b0;
    step("beqn.if", 4'd0, V_IFR);
    step("beqn.id", 4'd1, V_ID);
    step("beqn.ex", 4'd2, V_BRN);
    step("beqn.pcinc", 4'd6, V_PCI);

    inst = I_JAL;
    step("jal.if", 4'd0, V_IFR);
    step("jal.id", 4'd1, V_ID);
    step("jal.ex", 4'd2, V_JAL);

    inst = I_JALR;
    step("jalr.if", 4'd0, V_IFR);
    step("jalr.id", 4'd1, V_ID);
    step("jalr.ex", 4'd2, V_EXM);
    step("jalr.jalr2", 4'd5, V_JAL);

    inst = I_BAD;
    step("bad.if", 4'd0, V_IFR);
    step("bad.id", 4'd1, V_ID);
    step("bad.pcinc", 4'd6, V_PCI);

    inst = I_ECALL;
    chk("ecall_noh.if", {28'h0, state_o_0}, 32'd0);
    step("ecall.if", 4'd0, V_IFR);
    chk("ecall_noh.id", {28'h0, state_o_0}, 32'd1);
    chk("ecall_noh.id_outs", {16'h0, outs_0}, {16'h0, V_ID});
    step("ecall.id", 4'd1, V_ID);
    chk("ecall_noh.pcinc", {28'h0, state_o_0}, 32'd6);
    chk("ecall_noh.pcinc_outs", {16'h0, outs_0}, {16'h0, V_PCI});
    step("ecall.halt", 4'd7, V_HALT);
    chk("ecall_noh.if2", {28'h0, state_o_0}, 32'd0);
    for (int i = 0; i < 10; i++) step("ecall.halthold", 4'd7, V_HALT);

    #2 reset = 1'b1;
    #1;
    chk("halt_rst.state", {28'h0, state_o}, 32'd0);
    chk("halt_rst.halted", {31'h0, halted}, 32'd0);
    mem_ready = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("halt_rst.idle", {16'h0, outs}, {16'h0, V_IFN});

    inst = I_SW; mem_ready = 1'b1;
    step("swr.if", 4'd0, V_IFR);
    step("swr.id", 4'd1, V_ID);
    step("swr.ex", 4'd2, V_EXM);
    mem_ready = 1'b0;
    #1;
    chk("swr.mem_write_pre", {31'h0, mem_write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("swr.mem_write_rst", {31'h0, mem_write}, 32'd0);
    chk("swr.reg_write_rst", {31'h0, reg_write}, 32'd0);
    chk("swr.pc_write_rst", {31'h0, pc_write}, 32'd0);
    chk("swr.state_rst", {28'h0, state_o}, 32'd0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("swr.after_state", {28'h0, state_o}, 32'd0);
    chk("swr.after_mem_read", {31'h0, mem_read}, 32'd1);
    mem_ready = 1'b1;
    step("swr.refetch", 4'd0, V_IFR);
    step("swr.refetch_id", 4'd1, V_ID);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
